// File: rtl/cpu_vid_rx.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_vid_rx
//  Purpose  : Receiver for the parallel camera-to-CPU pixel bus. Oversamples
//             PCLK/VSYNC/HSYNC/VD on clk, detects PCLK rising edges, frames
//             the pixels through a one-pixel holding buffer and reports line
//             width, line count and framing errors.
//  Ports    : clk, rst            - system clock (>= 4x PCLK), async reset
//             bus_pclk/vsync/hsync/vd - asynchronous camera bus
//             pix_data/valid/sof/eol  - registered pixel stream
//             frame_done, line_width, frame_lines - frame statistics
//             err_width, err_abort    - error pulses
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_vid_rx #(
    parameter int DATA_W      = 14,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_pclk,
    input  logic              bus_vsync,
    input  logic              bus_hsync,
    input  logic [DATA_W-1:0] bus_vd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              frame_done,
    output logic [CNT_W-1:0]  line_width,
    output logic [CNT_W-1:0]  frame_lines,
    output logic              err_width,
    output logic              err_abort
);

    // Fewer than two synchronizer flops is never safe, so clamp silently.
    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int c_BUS_W  = DATA_W + 3;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_VS     = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronizers: every bus bit goes through the same chain so
    // PCLK, syncs and data are always taken from the same stage.
    // ------------------------------------------------------------------
    logic [c_STAGES-1:0][c_BUS_W-1:0] r_sync;
    logic [c_BUS_W-1:0]               w_bus_in;
    logic [c_BUS_W-1:0]               w_bus_s;
    logic                             w_pclk_s;
    logic                             r_pclk_d;

    assign w_bus_in = {bus_pclk, bus_vsync, bus_hsync, bus_vd};
    assign w_bus_s  = r_sync[c_STAGES-1];
    assign w_pclk_s = w_bus_s[DATA_W+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_pclk_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[c_STAGES-2:0], w_bus_in};
            r_pclk_d <= w_pclk_s;
        end
    end

    // ------------------------------------------------------------------
    // Edge-decode register: the PCLK rising-edge event and the bus fields
    // sampled with it are registered once so the framing logic starts
    // from flops rather than from the edge-detect gate.
    // ------------------------------------------------------------------
    logic              r_evt;
    logic              r_vs;
    logic              r_hs;
    logic [DATA_W-1:0] r_vd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt <= 1'b0;
            r_vs  <= 1'b0;
            r_hs  <= 1'b0;
            r_vd  <= '0;
        end else begin
            r_evt <= w_pclk_s & ~r_pclk_d;
            r_vs  <= w_bus_s[DATA_W+1];
            r_hs  <= w_bus_s[DATA_W];
            r_vd  <= w_bus_s[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Framing state machine with one-pixel holding buffer. A pixel is only
    // emitted once the next edge tells us whether it ended the line.
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_held;
    logic [DATA_W-1:0] r_hold;
    logic              r_sof_pending;
    logic [CNT_W-1:0]  r_col_cnt;
    logic [CNT_W-1:0]  r_line_cnt;
    logic [CNT_W-1:0]  r_ref_width;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_held        <= 1'b0;
            r_hold        <= '0;
            r_sof_pending <= 1'b0;
            r_col_cnt     <= '0;
            r_line_cnt    <= '0;
            r_ref_width   <= '0;
            pix_data      <= '0;
            pix_valid     <= 1'b0;
            pix_sof       <= 1'b0;
            pix_eol       <= 1'b0;
            frame_done    <= 1'b0;
            line_width    <= '0;
            frame_lines   <= '0;
            err_width     <= 1'b0;
            err_abort     <= 1'b0;
        end else begin
            // Strobes and pixel outputs are zero unless emitted this cycle.
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            err_width  <= 1'b0;
            err_abort  <= 1'b0;

            if (r_evt) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (r_vs) begin
                            r_state <= c_ST_VS;
                        end
                    end

                    c_ST_VS: begin
                        if (!r_vs) begin
                            r_state       <= c_ST_ACTIVE;
                            r_line_cnt    <= '0;
                            r_col_cnt     <= '0;
                            r_held        <= 1'b0;
                            r_sof_pending <= 1'b1;
                        end
                    end

                    c_ST_ACTIVE: begin
                        if (r_vs) begin
                            // Frame boundary. A held pixel means HSYNC was
                            // still high: flush it as a truncated line and
                            // drop the current vd; no width check.
                            r_state   <= c_ST_VS;
                            r_held    <= 1'b0;
                            r_col_cnt <= '0;
                            if (r_held) begin
                                pix_valid     <= 1'b1;
                                pix_data      <= r_hold;
                                pix_sof       <= r_sof_pending;
                                pix_eol       <= 1'b1;
                                r_sof_pending <= 1'b0;
                                err_abort     <= 1'b1;
                            end else if (r_line_cnt != '0) begin
                                frame_done  <= 1'b1;
                                frame_lines <= r_line_cnt;
                                line_width  <= r_ref_width;
                            end
                        end else if (r_hs) begin
                            if (r_held) begin
                                pix_valid     <= 1'b1;
                                pix_data      <= r_hold;
                                pix_sof       <= r_sof_pending;
                                r_sof_pending <= 1'b0;
                            end
                            r_hold <= r_vd;
                            r_held <= 1'b1;
                            if (r_col_cnt != c_CNT_MAX) begin
                                r_col_cnt <= r_col_cnt + 1'b1;
                            end
                        end else if (r_held) begin
                            // First HSYNC-low edge: the held pixel ends the line.
                            pix_valid     <= 1'b1;
                            pix_data      <= r_hold;
                            pix_sof       <= r_sof_pending;
                            pix_eol       <= 1'b1;
                            r_sof_pending <= 1'b0;
                            r_held        <= 1'b0;
                            r_col_cnt     <= '0;
                            if (r_line_cnt != c_CNT_MAX) begin
                                r_line_cnt <= r_line_cnt + 1'b1;
                            end
                            if (r_line_cnt == '0) begin
                                r_ref_width <= r_col_cnt;
                            end else if (r_col_cnt != r_ref_width) begin
                                err_width <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cpu_vid_rx.md
Name: cpu_vid_rx

Overview:
- Receiver for the parallel camera-to-CPU pixel bus: PCLK, VSYNC, HSYNC and VD[13:0].
- Oversamples the asynchronous bus on a single faster system clock, detects PCLK rising edges, and frames the pixels.
- Emits a pixel stream with start-of-frame and end-of-line flags, plus measured line width, line count and error pulses.
- Used as the loopback or capture end of the pixel bus for bring-up and for verification of the timing generator output.

Parameters:
- DATA_W, 14, pixel width.
- SYNC_STAGES, 2, synchronizer flops on every bus input (minimum 2).
- CNT_W, 12, width of the column, line and size counters.

Ports:
- clk  in  1  system clock; must be at least 4x the PCLK frequency.
- rst  in  1  asynchronous, active-high reset.
- bus_pclk  in  1  bus pixel clock, asynchronous to clk.
- bus_vsync  in  1  frame sync, active high; the frame starts after its falling edge.
- bus_hsync  in  1  line valid, active high; the pixel is valid while high.
- bus_vd  in  DATA_W  pixel data; stable around the PCLK rising edge.
- pix_data  out  DATA_W  output pixel.
- pix_valid  out  1  one-clk strobe per pixel.
- pix_sof  out  1  qualifies pix_valid: first pixel of the frame.
- pix_eol  out  1  qualifies pix_valid: last pixel of the line.
- frame_done  out  1  one-clk pulse at a normal frame end.
- line_width  out  CNT_W  pixel count of the first line of the last completed frame.
- frame_lines  out  CNT_W  line count of the last completed frame.
- err_width  out  1  one-clk pulse: a line length differs from the first line of the frame.
- err_abort  out  1  one-clk pulse: VSYNC asserted while HSYNC was high (truncated line).

Behaviour:
- Reset: all outputs 0, all counters 0, synchronizers 0, state IDLE. Reset mid-frame discards the held pixel and all partial counts; no pulse is generated.
- Input path:
  - All inputs pass through SYNC_STAGES flops, then one delay flop on PCLK.
  - An edge event e is 1 for one clk when the synchronized PCLK is 1 and the delayed PCLK is 0.
  - vd, hsync and vsync are taken from the same synchronized stage as PCLK.
- State machine, evaluated only on cycles where e=1:
  - IDLE: vsync=1 -> VS.
  - VS: vsync=0 -> ACTIVE. Clear line counter, set the sof_pending flag.
  - ACTIVE, vsync=1 with a held pixel present: emit the held pixel with eol=1, pulse err_abort, do not pulse frame_done, go to VS.
  - ACTIVE, vsync=1 with no held pixel: if line count >= 1, pulse frame_done, latch frame_lines and line_width, go to VS. If line count is 0, go to VS silently.
- One-pixel holding buffer (ACTIVE only):
  - On e with hsync=1: if a pixel is held, emit it with eol=0. Then load the current vd into the hold register and increment the column counter.
  - On e with hsync=0 and a pixel held: emit it with eol=1, then run end-of-line handling.
- Emit timing: pix_valid, pix_data, pix_sof and pix_eol are registered and assert on the clk edge after the e cycle. The sof/eol outputs are 0 whenever pix_valid=0.
- pix_sof is 1 on the first emitted pixel after VS->ACTIVE, then sof_pending is cleared.
- End of line:
  - Increment the line counter.
  - First line: store its column count as the reference width.
  - Later lines: if the column count differs from the reference, pulse err_width (the line is still emitted).
  - Clear the column counter.
- Latency: pixel N is emitted (SYNC_STAGES+2) clk after the PCLK rising edge of pixel N+1. The last pixel of a line is emitted relative to the first PCLK edge with hsync=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A line with 0 pixels (hsync never high) is not counted.
- Simultaneous events:
  - vsync=1 and hsync=1 on the same edge in ACTIVE: the abort rule wins and the current vd is dropped.
  - err_abort and err_width never pulse on the same cycle; abort suppresses the width check.
- Idle PCLK: no events, outputs hold at 0. PCLK gaps are tolerated.

Test Plan:
- Nominal 4x3 frame (vsync pulse, 3 lines of hsync=1 for 4 PCLK, pixel values 0x0001..0x000C) -> 12 pix_valid strobes carrying those values in order. pix_sof on 0x0001; pix_eol on 0x0004, 0x0008 and 0x000C. On the next vsync edge: frame_done, line_width=4, frame_lines=3, no errors.
- Latency check with clk=8x PCLK and SYNC_STAGES=2 -> pix_valid for pixel 1 rises exactly 4 clk after the sampled PCLK rising edge of pixel 2.
- Line lengths 4,4,5 -> err_width pulses once, on the eol of line 3. Next frame_done reports line_width=4, frame_lines=3.
- vsync asserted while hsync=1 after 2 pixels of line 2 -> pixel 2 of line 2 emitted with eol=1, err_abort=1, no frame_done. The next frame starts cleanly with pix_sof.
- Capture starting mid-frame (hsync toggling before any vsync) -> no pix_valid until after the first vsync falling edge.
- rst pulsed during line 2 -> all outputs 0 immediately. After rst release, output stays silent until the next vsync; the following frame reports correct sizes.
